// File: rtl/operand_hazard_ctrl_if.sv
// rtl/operand_hazard_ctrl_if.sv - issue-side bundle between decode and the operand hazard controller
interface operand_hazard_ctrl_if #(
    parameter int AW   = 5,
    parameter int CNTW = 16
);
    logic            issue_valid;
    logic [AW-1:0]   src1;
    logic [AW-1:0]   src2;
    logic            src2_used;
    logic [AW-1:0]   dst;
    logic            dst_valid;
    logic            is_load;
    logic            flush;
    logic            issue_ready;
    logic [1:0]      fwd_a;
    logic [1:0]      fwd_b;
    logic [1:0]      spec_sel;
    logic            rf_rd_a;
    logic            rf_rd_b;
    logic [CNTW-1:0] stall_count;

    modport master (
        output issue_valid, src1, src2, src2_used, dst, dst_valid, is_load, flush,
        input  issue_ready, fwd_a, fwd_b, spec_sel, rf_rd_a, rf_rd_b, stall_count
    );

    modport slave (
        input  issue_valid, src1, src2, src2_used, dst, dst_valid, is_load, flush,
        output issue_ready, fwd_a, fwd_b, spec_sel, rf_rd_a, rf_rd_b, stall_count
    );
endinterface

// File: rtl/operand_hazard_ctrl.sv
// rtl/operand_hazard_ctrl.sv - operand source selection, forwarding and load-use interlock for decode/issue
module operand_hazard_ctrl #(
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    operand_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] FWD_RF   = 2'd0;
    localparam logic [1:0] FWD_EX   = 2'd1;
    localparam logic [1:0] FWD_MEM  = 2'd2;
    localparam logic [1:0] FWD_SPEC = 2'd3;

    logic            ex_v;
    logic [AW-1:0]   ex_dst;
    logic            ex_ld;
    logic            mem_v;
    logic [AW-1:0]   mem_dst;
    logic [CNTW-1:0] stall_cnt;

    logic ex_hit_a, mem_hit_a, ex_hit_b, mem_hit_b;
    logic b_reg, hazard, stall, accept;

    // Special codes (MSB set) are never RF registers, so they never match a slot.
    assign ex_hit_a  = ex_v  && !bus.src1[AW-1] && (ex_dst  == bus.src1);
    assign mem_hit_a = mem_v && !bus.src1[AW-1] && (mem_dst == bus.src1);
    assign b_reg     = bus.src2_used && !bus.src2[AW-1];
    assign ex_hit_b  = b_reg && ex_v  && (ex_dst  == bus.src2);
    assign mem_hit_b = b_reg && mem_v && (mem_dst == bus.src2);

    assign hazard = bus.issue_valid && ex_ld && (ex_hit_a || ex_hit_b);
    assign stall  = hazard && !bus.flush;
    assign accept = bus.issue_valid && !stall && !bus.flush;

    always_comb begin
        bus.issue_ready = !stall;
        bus.fwd_a       = FWD_RF;
        bus.fwd_b       = FWD_RF;
        bus.spec_sel    = 2'd0;
        bus.rf_rd_a     = 1'b0;
        bus.rf_rd_b     = 1'b0;
        if (bus.issue_valid && !stall) begin
            if (bus.src1[AW-1]) begin
                bus.fwd_a = FWD_SPEC;
                if (bus.src1 == AW'(17))      bus.spec_sel = 2'd1;
                else if (bus.src1 == AW'(21)) bus.spec_sel = 2'd2;
                else if (bus.src1 == AW'(20)) bus.spec_sel = 2'd3;
                else                          bus.spec_sel = 2'd0;
            end else if (ex_hit_a) begin
                bus.fwd_a = FWD_EX;
            end else if (mem_hit_a) begin
                bus.fwd_a = FWD_MEM;
            end else begin
                bus.rf_rd_a = 1'b1;
            end

            if (ex_hit_b)       bus.fwd_b = FWD_EX;
            else if (mem_hit_b) bus.fwd_b = FWD_MEM;
            else                bus.rf_rd_b = b_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_v      <= 1'b0;
            ex_dst    <= '0;
            ex_ld     <= 1'b0;
            mem_v     <= 1'b0;
            mem_dst   <= '0;
            stall_cnt <= '0;
        end else begin
            if (bus.flush) begin
                ex_v  <= 1'b0;
                ex_ld <= 1'b0;
                mem_v <= 1'b0;
            end else begin
                mem_v   <= ex_v;
                mem_dst <= ex_dst;
                // Untracked or non-accepted cycles enter EX as a bubble.
                ex_v    <= accept && bus.dst_valid && !bus.dst[AW-1];
                ex_dst  <= bus.dst;
                ex_ld   <= accept && bus.is_load;
            end
            if (stall && (stall_cnt != {CNTW{1'b1}}))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

    assign bus.stall_count = stall_cnt;
endmodule

// File: tb/tb_operand_hazard_ctrl.sv
// tb/tb_operand_hazard_ctrl.sv - scoreboard bench for operand_hazard_ctrl against a pipeline-history model
module tb_operand_hazard_ctrl;
    localparam int AW = 5;
    localparam int CW = 6;

    typedef struct packed {
        logic          rdy;
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic [1:0]    ss;
        logic          ra;
        logic          rb;
        logic [CW-1:0] cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    operand_hazard_ctrl_if #(.AW(AW), .CNTW(CW)) bus();
    operand_hazard_ctrl #(.AW(AW), .CNTW(CW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    // Model: the last two cycles' issue records, index 0 = previous cycle (EX), 1 = two ago (MEM).
    logic          h_v[2];
    logic [AW-1:0] h_dst[2];
    logic          h_ld[2];
    int            m_cnt;

    function automatic int youngest_writer(logic [AW-1:0] code);
        if (code[AW-1]) return 0;
        for (int i = 0; i < 2; i++)
            if (h_v[i] && h_dst[i] == code) return i + 1;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            h_v[i] = 1'b0; h_dst[i] = '0; h_ld[i] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic chk(string name, int act, int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    // One clock: drive, predict, push, advance, then update model history.
    task automatic cycle(input logic iv, input int s1, input int s2, input logic s2u,
                         input int d, input logic dv, input logic ld, input logic fl);
        exp_t e;
        int   a_src, b_src;
        logic stall, acc;
        bus.issue_valid = iv;
        bus.src1 = AW'(s1); bus.src2 = AW'(s2); bus.src2_used = s2u;
        bus.dst = AW'(d); bus.dst_valid = dv; bus.is_load = ld; bus.flush = fl;

        a_src = youngest_writer(AW'(s1));
        b_src = (s2u && (s2 < 16)) ? youngest_writer(AW'(s2)) : 0;
        stall = iv && !fl && h_v[0] && h_ld[0] && (a_src == 1 || b_src == 1);
        acc   = iv && !stall && !fl;

        e = '0;
        e.rdy = !stall;
        e.cnt = CW'(m_cnt);
        if (iv && !stall) begin
            if (s1 >= 16) begin
                e.fa = 2'd3;
                e.ss = (s1 == 17) ? 2'd1 : (s1 == 21) ? 2'd2 : (s1 == 20) ? 2'd3 : 2'd0;
            end else begin
                e.fa = 2'(a_src);
                e.ra = (a_src == 0);
            end
            e.fb = 2'(b_src);
            e.rb = s2u && (s2 < 16) && (b_src == 0);
        end
        exp_q.push_back(e);

        @(posedge clk);
        if (stall && m_cnt < (1 << CW) - 1) m_cnt++;
        if (fl) begin
            h_v[0] = 1'b0; h_v[1] = 1'b0; h_ld[0] = 1'b0; h_ld[1] = 1'b0;
        end else begin
            h_v[1] = h_v[0]; h_dst[1] = h_dst[0]; h_ld[1] = h_ld[0];
            h_v[0] = acc && dv && (d < 16);
            h_dst[0] = AW'(d);
            h_ld[0] = acc && ld;
        end
        #1;
    endtask

    task automatic idle();
        cycle(1'b0, 0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.issue_valid = 1'b0; bus.flush = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("issue_ready", int'(bus.issue_ready), int'(e.rdy));
            chk("fwd_a",       int'(bus.fwd_a),       int'(e.fa));
            chk("fwd_b",       int'(bus.fwd_b),       int'(e.fb));
            chk("spec_sel",    int'(bus.spec_sel),    int'(e.ss));
            chk("rf_rd_a",     int'(bus.rf_rd_a),     int'(e.ra));
            chk("rf_rd_b",     int'(bus.rf_rd_b),     int'(e.rb));
            chk("stall_count", int'(bus.stall_count), int'(e.cnt));
        end
    end

    initial begin
        bus.issue_valid = 1'b0; bus.src1 = '0; bus.src2 = '0; bus.src2_used = 1'b0;
        bus.dst = '0; bus.dst_valid = 1'b0; bus.is_load = 1'b0; bus.flush = 1'b0;
        model_reset();
        do_reset();
        idle();

        // Back-to-back ALU forwarding EX -> MEM -> RF.
        cycle(1, 1, 16, 0, 3, 1, 0, 0);
        cycle(1, 3, 3, 1, 9, 0, 0, 0);
        cycle(1, 3, 16, 0, 9, 0, 0, 0);
        cycle(1, 3, 16, 0, 9, 0, 0, 0);

        // Load-use: one stall, then MEM forward on B.
        cycle(1, 1, 16, 0, 5, 1, 1, 0);
        cycle(1, 2, 5, 1, 6, 1, 0, 0);
        cycle(1, 2, 5, 1, 6, 1, 0, 0);

        // Special sources and immediate B.
        cycle(1, 17, 16, 1, 0, 0, 0, 0);
        cycle(1, 21, 16, 1, 0, 0, 0, 0);
        cycle(1, 20, 16, 1, 0, 0, 0, 0);
        cycle(1, 16, 16, 1, 0, 0, 0, 0);

        // Youngest writer wins; special destinations never forward.
        cycle(1, 0, 16, 0, 7, 1, 0, 0);
        cycle(1, 0, 16, 0, 7, 1, 0, 0);
        cycle(1, 7, 7, 1, 18, 1, 0, 0);
        cycle(1, 2, 18, 1, 0, 0, 0, 0);

        // Flush during a load-use stall.
        cycle(1, 1, 16, 0, 5, 1, 1, 0);
        cycle(1, 5, 16, 0, 8, 1, 0, 1);
        cycle(1, 5, 16, 0, 8, 1, 0, 0);

        // Saturation: a self-dependent load chain stalls every other cycle.
        for (int i = 0; i < 2 * ((1 << CW) + 3) + 2; i++)
            cycle(1, 5, 16, 0, 5, 1, 1, 0);
        do_reset();
        idle();
        cycle(1, 5, 5, 1, 0, 0, 0, 0);

        // Randomized traffic biased toward a few register codes so hazards recur.
        for (int i = 0; i < 1500; i++) begin
            int s1, s2, d;
            s1 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 23)) : int'($urandom_range(0, 5));
            s2 = ($urandom_range(0, 5) == 0) ? int'($urandom_range(16, 23)) : int'($urandom_range(0, 5));
            d  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(16, 23)) : int'($urandom_range(0, 5));
            cycle(($urandom_range(0, 7) != 0), s1, s2, 1'($urandom_range(0, 1)), d,
                  ($urandom_range(0, 4) != 0), ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 15) == 0));
        end

        idle();
        @(negedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
